// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA raster counters, sync/blank generation and latency-matched pixel output stage.
module vga_timing_out #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int COLOR_W  = 4,
  parameter int PIPE     = 1
) (
  input  logic               CLK_VGA,
  input  logic               RESET_N,
  input  logic               PATTERN_EN,
  input  logic [COLOR_W-1:0] VGA_RED_CHAN,
  input  logic [COLOR_W-1:0] VGA_GREEN_CHAN,
  input  logic [COLOR_W-1:0] VGA_BLUE_CHAN,
  output logic [11:0]        VGA_HORZ_COORD,
  output logic [11:0]        VGA_VERT_COORD,
  output logic               VGA_ACTIVE,
  output logic               LINE_START,
  output logic               FRAME_START,
  output logic [COLOR_W-1:0] VGA_RED,
  output logic [COLOR_W-1:0] VGA_GREEN,
  output logic [COLOR_W-1:0] VGA_BLUE,
  output logic               VGA_HS,
  output logic               VGA_VS
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] HMAX = 12'(H_TOTAL - 1);
  localparam logic [11:0] VMAX = 12'(V_TOTAL - 1);
  localparam logic [11:0] BWM  = 12'(H_ACTIVE / 8 - 1);
  localparam logic [12:0] HA   = 13'(H_ACTIVE);
  localparam logic [12:0] HS0  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS1  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] VA   = 13'(V_ACTIVE);
  localparam logic [12:0] VS0  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS1  = 13'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vga_timing_out: H_TOTAL and V_TOTAL must not exceed 4096");
  end
  if (PIPE < 0 || PIPE > 8 || H_ACTIVE % 8 != 0) begin : g_bad_cfg
    $error("vga_timing_out: PIPE must be 0..8 and H_ACTIVE divisible by 8");
  end

  logic [11:0] h_q, h_d, v_q, v_d, bc_q, bc_d;
  logic [2:0]  bi_q, bi_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic hs_q, hs_d, vs_q, vs_d;
  logic h_wrap, bc_wrap, act, hs_raw, vs_raw;
  logic [12:0] hx, vx;
  logic [5:0]  cur, dly;

  always_comb begin
    hx      = {1'b0, h_q};
    vx      = {1'b0, v_q};
    h_wrap  = h_q == HMAX;
    bc_wrap = bc_q == BWM;
    h_d     = h_wrap ? '0 : h_q + 12'd1;
    v_d     = !h_wrap ? v_q : (v_q == VMAX) ? '0 : v_q + 12'd1;
    bc_d    = (h_wrap || bc_wrap) ? '0 : bc_q + 12'd1;
    bi_d    = h_wrap ? '0 : bc_wrap ? bi_q + 3'd1 : bi_q;
    act     = hx < HA && vx < VA;
    hs_raw  = hx >= HS0 && hx < HS1;
    vs_raw  = vx >= VS0 && vx < VS1;
    cur     = {act, hs_raw, vs_raw, act ? bi_q : 3'd0};
    r_d     = !dly[5] ? '0 : PATTERN_EN ? {COLOR_W{dly[2]}} : VGA_RED_CHAN;
    g_d     = !dly[5] ? '0 : PATTERN_EN ? {COLOR_W{dly[1]}} : VGA_GREEN_CHAN;
    b_d     = !dly[5] ? '0 : PATTERN_EN ? {COLOR_W{dly[0]}} : VGA_BLUE_CHAN;
    hs_d    = dly[4] ? HS_POL : ~HS_POL;
    vs_d    = dly[3] ? VS_POL : ~VS_POL;
  end

  // {active, hs, vs, bar index} delayed to line up with the renderer's colour
  if (PIPE == 0) begin : g_nopipe
    assign dly = cur;
  end else begin : g_pipe
    localparam int SW = 6 * PIPE;
    logic [SW-1:0] sr_q, sr_d;
    assign sr_d = SW'({sr_q, cur});
    assign dly  = sr_q[SW-1 -: 6];
    always_ff @(posedge CLK_VGA or negedge RESET_N)
      if (!RESET_N) sr_q <= '0;
      else sr_q <= sr_d;
  end

  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      h_q  <= '0;
      v_q  <= '0;
      bc_q <= '0;
      bi_q <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      bc_q <= bc_d;
      bi_q <= bi_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
    end
  end

  assign VGA_HORZ_COORD = h_q;
  assign VGA_VERT_COORD = v_q;
  assign VGA_ACTIVE     = act;
  assign LINE_START     = h_q == 12'd0;
  assign FRAME_START    = h_q == 12'd0 && v_q == 12'd0;
  assign VGA_RED        = r_q;
  assign VGA_GREEN      = g_q;
  assign VGA_BLUE       = b_q;
  assign VGA_HS         = hs_q;
  assign VGA_VS         = vs_q;
endmodule
